// File: rtl/compact_pkg.sv
// compact_pkg: shared types, widths and helpers for the compact_accum slice.
//   state_t      : FILL / DRAIN controller states
//   ptr_bits(n)  : ring pointer width for n lanes (ring depth 2n)
//   cnt_bits(n)  : occupancy width for n lanes (holds 0..2n)
//   ptr_t/cnt_t  : pointer/count types for the default lane count
//   popcount(v)  : number of set bits in a lane mask (zero-extended to POP_MAX)
package compact_pkg;

  localparam int unsigned LANES_DEF = 8;
  localparam int unsigned POP_MAX   = 256;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int unsigned ptr_bits(input int unsigned n);
    return $clog2(2 * n);
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned n);
    return $clog2(2 * n) + 1;
  endfunction

  typedef logic [$clog2(2 * LANES_DEF)-1:0] ptr_t;
  typedef logic [$clog2(2 * LANES_DEF):0]   cnt_t;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned k = 0; k < POP_MAX; k++) begin
      c += 32'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/compact_ring.sv
// compact_ring: circular lane buffer of depth 2N.
//   clk     : write clock (storage is not reset; contents are don't-care until written)
//   wr_en   : write strobe
//   wr_ptr  : slot receiving lane 0 of wr_data
//   wr_cnt  : number of lanes (from lane 0 upward) to store
//   wr_data : N input lanes
//   rd_ptr  : slot presented on rd_data lane 0
//   rd_data : N consecutive slots starting at rd_ptr (combinational read)
module compact_ring
  import compact_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = LANES_DEF
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_bits(N)-1:0]      wr_ptr,
  input  logic [cnt_bits(N)-1:0]      wr_cnt,
  input  logic [N-1:0][DW-1:0]        wr_data,
  input  logic [ptr_bits(N)-1:0]      rd_ptr,
  output logic [N-1:0][DW-1:0]        rd_data
);

  localparam int unsigned PW    = ptr_bits(N);
  localparam int unsigned DEPTH = 2 * N;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_idx [N];
  logic [PW-1:0] rd_idx [N];

  // Depth is a power of two, so slot indices wrap by plain truncation.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      wr_idx[k]  = wr_ptr + PW'(k);
      rd_idx[k]  = rd_ptr + PW'(k);
      rd_data[k] = mem[rd_idx[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (k < 32'(wr_cnt)) begin
          mem[wr_idx[k]] <= wr_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/compact_accum.sv
// compact_accum: accumulates compacted lane beats into full N-lane output beats,
// flushing a partial beat at end of packet.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_data     : N input lanes, valid lanes contiguous from lane 0
//   i_valid    : input lane mask
//   i_last     : end of packet, flush after this beat
//   i_ready    : beat accepted while high (FILL and at most N entries buffered)
//   o_data     : N output lanes (lanes above o_valid are don't-care)
//   o_valid    : output lane mask, beat presented when non-zero
//   o_last     : final beat of a flush
//   o_ready    : downstream accepts the presented beat
//   o_err      : sticky non-contiguous input mask flag
// Build option: define COMPACT_ACCUM_CHK_EN to enable the mask checker that
// drives o_err; otherwise o_err is tied low.
module compact_accum
  import compact_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = LANES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0][DW-1:0] i_data,
  input  logic [N-1:0]         i_valid,
  input  logic                 i_last,
  output logic                 i_ready,
  output logic [N-1:0][DW-1:0] o_data,
  output logic [N-1:0]         o_valid,
  output logic                 o_last,
  input  logic                 o_ready,
  output logic                 o_err
);

  localparam int unsigned PW = ptr_bits(N);
  localparam int unsigned CW = cnt_bits(N);

  typedef logic [PW-1:0] lptr_t;
  typedef logic [CW-1:0] lcnt_t;

  localparam lcnt_t CNT_N = lcnt_t'(N);

  state_t state, state_nx;
  lcnt_t  count, count_nx;
  lcnt_t  in_cnt, out_cnt, pop_cnt, add_cnt;
  lptr_t  head, head_nx, wr_ptr;
  logic   present, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
      head  <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      head  <= head_nx;
    end
  end

  // Accepting only when count <= N keeps count + popcount within 2N.
  assign i_ready = (state == FILL) && (count <= CNT_N);
  assign in_cnt  = lcnt_t'(popcount(POP_MAX'(i_valid)));
  assign out_cnt = (count >= CNT_N) ? CNT_N : count;
  // Only used while i_ready, where count <= N, so truncation cannot alias.
  assign wr_ptr  = head + lptr_t'(count);

  always_comb begin
    present  = 1'b0;
    o_last   = 1'b0;
    o_valid  = '0;
    pop      = 1'b0;
    pop_cnt  = '0;
    add_cnt  = '0;
    head_nx  = head;
    state_nx = state;

    case (state)
      FILL:    present = (count >= CNT_N);
      DRAIN:   present = (count != '0);
      default: present = 1'b0;
    endcase

    o_last = present && (state == DRAIN) && (count <= CNT_N);

    for (int unsigned k = 0; k < N; k++) begin
      o_valid[k] = present && (k < 32'(out_cnt));
    end

    pop = present && o_ready;
    if (pop) begin
      pop_cnt = out_cnt;
      head_nx = head + lptr_t'(out_cnt);
    end
    if (i_ready) begin
      add_cnt = in_cnt;
    end
    count_nx = count - pop_cnt + add_cnt;

    case (state)
      FILL: begin
        if (i_ready && i_last && (count_nx != '0)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && o_last) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // Lanes 0..popcount-1 are stored; with a well-formed mask these are exactly
  // the valid lanes.
  compact_ring #(
    .DW(DW),
    .N (N)
  ) u_ring (
    .clk    (clk),
    .wr_en  (i_ready),
    .wr_ptr (wr_ptr),
    .wr_cnt (in_cnt),
    .wr_data(i_data),
    .rd_ptr (head),
    .rd_data(o_data)
  );

`ifdef COMPACT_ACCUM_CHK_EN
  logic [N-1:0] valid_inc;
  logic         err_q;

  // A mask contiguous from lane 0 has the form 0..01..1, so adding one
  // clears every set bit; any surviving overlap means a 1 sits above a 0.
  assign valid_inc = i_valid + N'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (i_ready && ((i_valid & valid_inc) != '0)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
